// File: rtl/irl_input_conditioner.sv
// irl_input_conditioner
// Conditions the raw board inputs (enable switch, step push-button, disable
// switch) for the IRL next-state logic. Each input passes through a 2-FF
// synchronizer and a counter debouncer. The debounced step level is turned
// into a single-cycle w[0] pulse on its rising edge, so one press advances
// the downstream 3-bit state exactly once.
//
// Output map:
//   w[1]     debounced enable level
//   w[0]     one-cycle pulse on each accepted step press
//   d        debounced disable level
//   step_lvl debounced step level (debug/LED)

// ---------------------------------------------------------------------------
// irl_db_channel
// One synchronize-and-debounce channel. The stable level only follows the
// synchronized input after DB_CYCLES consecutive edges at which the two
// disagree; any shorter disagreement is forgotten and the count restarts
// from zero. The counter tops out at DB_CYCLES-1 and never wraps.
// ---------------------------------------------------------------------------
module irl_db_channel #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 20
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Two-stage synchronizer for the asynchronous raw input.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce decision: clear on agreement, accept on the last mismatch, else count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Debounce state registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;

endmodule

// ---------------------------------------------------------------------------
// irl_input_conditioner (top)
// Three independent channels plus the rising-edge detector on the step level.
// Channels share nothing but the clock and reset, so several of them may
// accept a new level on the same edge. w[0] is deliberately not gated by the
// enable or disable levels; that qualification happens downstream.
// ---------------------------------------------------------------------------
module irl_input_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 20
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       en_raw,
    input  logic       step_raw,
    input  logic       dis_raw,
    output logic [1:0] w,
    output logic       d,
    output logic       step_lvl
);

    logic s_en;
    logic s_step;
    logic s_dis;
    logic step_prev_q;

    irl_db_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_en (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .raw_i   (en_raw),
        .level_o (s_en)
    );

    irl_db_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_step (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .raw_i   (step_raw),
        .level_o (s_step)
    );

    irl_db_channel #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_db_dis (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .raw_i   (dis_raw),
        .level_o (s_dis)
    );

    // Delayed copy of the debounced step level for rising-edge detection.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= s_step;
        end
    end

    // Levels are passed straight through; the pulse is high only in the
    // cycle right after the step level goes 0->1 (holding or releasing the
    // button cannot produce another one).
    assign w        = {s_en, s_step & ~step_prev_q};
    assign d        = s_dis;
    assign step_lvl = s_step;

endmodule
